pci_arbiter: RTL

Central PCI bus arbiter that shares the AD/CBE/FRAME#/IRDY# bus between up to N bus masters (Device_new-class agents) using active-low REQ#/GNT# pairs. Watches FRAME#/IRDY# to track bus idle/busy. Grants round-robin, parks the bus on a default master when nobody requests, and revokes stalled grants after a timeout. Sits at system level beside the target devices.

---
 rtl/pci_arbiter_if.sv | 23 ++
 rtl/pci_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pci_arbiter_if.sv
// PCI arbitration signal bundle: shared FRAME#/IRDY# plus per-master REQ#/GNT# pairs.
// The master modport is the arbiter's view; slave is the agents'/bench's view.
interface pci_arbiter_if #(
  parameter int N_MASTERS = 4,
  parameter int IDW       = 2
);
  logic                 FRAME;
  logic                 IRDY;
  logic [N_MASTERS-1:0] REQ;
  logic [N_MASTERS-1:0] GNT;
  logic [IDW-1:0]       GNT_ID;
  logic                 BUS_BUSY;

  modport master (
    input  FRAME, IRDY, REQ,
    output GNT, GNT_ID, BUS_BUSY
  );

  modport slave (
    output FRAME, IRDY, REQ,
    input  GNT, GNT_ID, BUS_BUSY
  );
endinterface

// File: rtl/pci_arbiter.sv
// Central PCI arbiter: round-robin REQ#/GNT# grants, bus parking, idle-grant timeout,
// and a mandatory all-GNT#-high turnaround cycle whenever ownership can change.
module pci_arbiter #(
  parameter int N_MASTERS    = 4,
  parameter int PARK_MASTER  = 0,
  parameter int IDLE_TIMEOUT = 16,
  parameter int IDW          = 2
)(
  input logic          CLK,
  input logic          RST,
  pci_arbiter_if.master bus
);

  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {S_DEAD, S_GRANTED, S_BUSY} state_t;

  state_t               r_state;
  logic [N_MASTERS-1:0] r_gnt;
  logic [IDW-1:0]       r_gnt_id;
  logic [IDW-1:0]       r_rr_ptr;
  logic [TW-1:0]        r_timer;
  logic                 r_busy;
  logic                 r_parked;
  logic                 r_started;

  logic [N_MASTERS-1:0] w_req;
  logic                 w_idle;
  logic                 w_other;
  logic                 w_owner_req;
  logic [IDW-1:0]       w_win;
  logic                 w_win_req;

  // Undriven or unknown REQ# lines count as "not requesting".
  always_comb begin
    w_req       = '0;
    w_other     = 1'b0;
    w_owner_req = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      w_req[i] = (bus.REQ[i] === 1'b0);
      if (IDW'(i) == r_gnt_id) w_owner_req = w_req[i];
      else if (w_req[i])       w_other     = 1'b1;
    end
  end

  assign w_idle = (bus.FRAME == 1'b1) && (bus.IRDY == 1'b1);

  // Descending scan so the requester closest to r_rr_ptr is assigned last and wins.
  always_comb begin
    w_win     = IDW'(PARK_MASTER);
    w_win_req = 1'b0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (w_req[i] && (i == ((int'(r_rr_ptr) + k) % N_MASTERS))) begin
          w_win     = IDW'(i);
          w_win_req = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_DEAD;
      r_gnt     <= {N_MASTERS{1'b1}};
      r_gnt_id  <= IDW'(PARK_MASTER);
      r_rr_ptr  <= '0;
      r_timer   <= '0;
      r_busy    <= 1'b0;
      r_parked  <= 1'b0;
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
      case (r_state)
        S_DEAD: begin
          // The first edge after reset release is spent here so the first grant lands on the second.
          if (r_started) begin
            r_gnt    <= ~(N_MASTERS'(1) << w_win);
            r_gnt_id <= w_win;
            r_timer  <= '0;
            r_parked <= !w_win_req;
            if (w_win_req) r_rr_ptr <= IDW'((int'(w_win) + 1) % N_MASTERS);
            r_state  <= S_GRANTED;
          end
        end
        S_GRANTED: begin
          if (bus.FRAME == 1'b0) begin
            r_state <= S_BUSY;
            r_busy  <= 1'b1;
            r_timer <= '0;
          end else if (w_other && (!w_owner_req || r_parked)) begin
            r_state <= S_DEAD;
            r_gnt   <= {N_MASTERS{1'b1}};
          end else if (w_other && (r_timer == TW'(IDLE_TIMEOUT - 1))) begin
            r_state <= S_DEAD;
            r_gnt   <= {N_MASTERS{1'b1}};
          end else if (w_other) begin
            if (r_timer != TW'(IDLE_TIMEOUT - 1)) r_timer <= r_timer + 1'b1;
          end else begin
            r_timer <= '0;
          end
        end
        S_BUSY: begin
          // GNT# is dropped once and never re-asserted; the owner finishes on its latency timer.
          if (w_idle) begin
            r_state <= S_DEAD;
            r_busy  <= 1'b0;
            r_gnt   <= {N_MASTERS{1'b1}};
          end else if (!w_owner_req || w_other) begin
            r_gnt   <= {N_MASTERS{1'b1}};
          end
        end
        default: begin
          r_state <= S_DEAD;
          r_gnt   <= {N_MASTERS{1'b1}};
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.GNT      = r_gnt;
  assign bus.GNT_ID   = r_gnt_id;
  assign bus.BUS_BUSY = r_busy;

endmodule
